// File: rtl/apa102_stream_rx.sv
// apa102_stream_rx: oversampling receiver for the two-wire LED-matrix stream.
// Finds the 32-zero start frame, shifts in NUM_LEDS 32-bit pixel words MSB first,
// presents each word in parallel with its index, then checks the 32-zero end frame.
module apa102_stream_rx #(
    parameter int NUM_LEDS = 64,
    parameter int IDX_W    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sclk_in,
    input  logic             sdata_in,
    output logic             pix_valid,
    output logic [IDX_W-1:0] pix_index,
    output logic [4:0]       pix_bright,
    output logic [7:0]       pix_blue,
    output logic [7:0]       pix_green,
    output logic [7:0]       pix_red,
    output logic             frame_start,
    output logic             frame_done,
    output logic             frame_err,
    output logic             rx_busy
);

    typedef enum logic [1:0] {S_HUNT, S_SYNC, S_PIXEL, S_END} state_t;

    localparam logic [IDX_W-1:0] LAST_LED = IDX_W'(NUM_LEDS - 1);

    state_t           state_q, state_d;
    logic [2:0]       sclk_q;     // [1:0] synchronizer, [2] edge-detect history
    logic [1:0]       sdata_q;
    logic [5:0]       zero_run_q, zero_run_d;
    logic [5:0]       bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0] led_cnt_q, led_cnt_d;
    logic [31:0]      shift_q, shift_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [28:0]      fields_q, fields_d;
    logic             pix_valid_q, pix_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_err_q, frame_err_d;

    logic             fall;
    logic             bit_in;
    logic [5:0]       zr_inc;
    logic [31:0]      shift_nxt;

    // Both lines see the same synchronizer depth, so data and clock stay aligned.
    assign fall      = sclk_q[2] & ~sclk_q[1];
    assign bit_in    = sdata_q[1];
    assign zr_inc    = (zero_run_q == 6'd32) ? zero_run_q : zero_run_q + 6'd1;
    assign shift_nxt = {shift_q[30:0], bit_in};

    // Synchronize the serial lines; reset value 0 keeps a high sclk from faking an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_q  <= '0;
            sdata_q <= '0;
        end else begin
            sclk_q  <= {sclk_q[1:0], sclk_in};
            sdata_q <= {sdata_q[0], sdata_in};
        end
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_HUNT;
            zero_run_q    <= '0;
            bit_cnt_q     <= '0;
            led_cnt_q     <= '0;
            shift_q       <= '0;
            index_q       <= '0;
            fields_q      <= '0;
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            zero_run_q    <= zero_run_d;
            bit_cnt_q     <= bit_cnt_d;
            led_cnt_q     <= led_cnt_d;
            shift_q       <= shift_d;
            index_q       <= index_d;
            fields_q      <= fields_d;
            pix_valid_q   <= pix_valid_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            frame_err_q   <= frame_err_d;
        end
    end

    // One framing step per sampled bit (falling sclk edge).
    always_comb begin
        state_d       = state_q;
        zero_run_d    = zero_run_q;
        bit_cnt_d     = bit_cnt_q;
        led_cnt_d     = led_cnt_q;
        shift_d       = shift_q;
        index_d       = index_q;
        fields_d      = fields_q;
        pix_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        frame_err_d   = 1'b0;
        if (fall) begin
            case (state_q)
                S_HUNT: begin
                    if (bit_in) begin
                        zero_run_d = '0;
                    end else begin
                        zero_run_d = zr_inc;
                        if (zr_inc == 6'd32) state_d = S_SYNC;
                    end
                end
                S_SYNC: begin
                    // The first 1 after the start frame is bit 31 of pixel 0.
                    if (bit_in) begin
                        frame_start_d = 1'b1;
                        shift_d       = 32'd1;
                        bit_cnt_d     = 6'd1;
                        led_cnt_d     = '0;
                        state_d       = S_PIXEL;
                    end
                end
                S_PIXEL: begin
                    shift_d   = shift_nxt;
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_q == 6'd31) begin
                        if (shift_nxt[31:29] == 3'b111) begin
                            fields_d    = shift_nxt[28:0];
                            index_d     = led_cnt_q;
                            pix_valid_d = 1'b1;
                            led_cnt_d   = led_cnt_q + IDX_W'(1);
                            if (led_cnt_q == LAST_LED) begin
                                state_d    = S_END;
                                zero_run_d = '0;
                            end else begin
                                bit_cnt_d = '0;
                            end
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = S_HUNT;
                            zero_run_d  = '0;
                        end
                    end
                end
                S_END: begin
                    if (bit_in) begin
                        frame_err_d = 1'b1;
                        state_d     = S_HUNT;
                        zero_run_d  = '0;
                    end else if (zr_inc == 6'd32) begin
                        frame_done_d = 1'b1;
                        state_d      = S_HUNT;
                        zero_run_d   = '0;
                    end else begin
                        zero_run_d = zr_inc;
                    end
                end
                default: state_d = S_HUNT;
            endcase
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_index   = index_q;
    assign pix_bright  = fields_q[28:24];
    assign pix_blue    = fields_q[23:16];
    assign pix_green   = fields_q[15:8];
    assign pix_red     = fields_q[7:0];
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign frame_err   = frame_err_q;
    assign rx_busy     = (state_q == S_PIXEL) || (state_q == S_END);

endmodule

// File: tb/tb_apa102_stream_rx.sv
// tb_apa102_stream_rx: directed scenarios with random pixel words and sdata skew,
// checked against a frame parser that works directly on the transmitted bit list.
module tb_apa102_stream_rx;
    localparam int NUM_LEDS = 64;
    localparam int IDX_W    = 6;
    localparam logic [1:0] K_S = 2'd0, K_P = 2'd1, K_D = 2'd2, K_E = 2'd3;

    typedef struct packed {
        logic [1:0]       kind;
        logic [IDX_W-1:0] idx;
        logic [28:0]      f;
    } ev_t;

    logic clk = 1'b0, reset = 1'b1, sclk_in = 1'b0, sdata_in = 1'b0;
    logic pix_valid, frame_start, frame_done, frame_err, rx_busy;
    logic [IDX_W-1:0] pix_index;
    logic [4:0] pix_bright;
    logic [7:0] pix_blue, pix_green, pix_red;

    int checks = 0, failures = 0;
    ev_t obs_q[$];
    ev_t exp_q[$];
    bit sq[$];
    int sent = 0, obs_rd = 0, multi = 0, multi_base = 0;
    logic [31:0] words[8];

    apa102_stream_rx #(.NUM_LEDS(NUM_LEDS), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .sclk_in(sclk_in), .sdata_in(sdata_in),
        .pix_valid(pix_valid), .pix_index(pix_index), .pix_bright(pix_bright),
        .pix_blue(pix_blue), .pix_green(pix_green), .pix_red(pix_red),
        .frame_start(frame_start), .frame_done(frame_done), .frame_err(frame_err),
        .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    function automatic ev_t mk(input logic [1:0] k, input logic [IDX_W-1:0] i, input logic [28:0] f);
        ev_t e;
        e.kind = k; e.idx = i; e.f = f;
        return e;
    endfunction

    // Record every strobe seen on the DUT outputs, away from the active edge.
    always @(negedge clk) begin
        int n;
        n = int'(pix_valid) + int'(frame_start) + int'(frame_done) + int'(frame_err);
        if (n > 1) multi++;
        if (frame_start) obs_q.push_back(mk(K_S, '0, '0));
        if (pix_valid)   obs_q.push_back(mk(K_P, pix_index, {pix_bright, pix_blue, pix_green, pix_red}));
        if (frame_done)  obs_q.push_back(mk(K_D, '0, '0));
        if (frame_err)   obs_q.push_back(mk(K_E, '0, '0));
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_zeros(input int n);
        for (int i = 0; i < n; i++) sq.push_back(1'b0);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) sq.push_back(w[i]);
    endtask

    function automatic logic [31:0] rnd_word();
        return {3'b111, 29'($urandom)};
    endfunction

    // Transmit all not-yet-sent bits: data launched at a random point in the high phase.
    task automatic send(input int hi, input int lo);
        for (int i = sent; i < sq.size(); i++) begin
            int skew;
            skew = $urandom_range(hi - 2, 0);
            @(posedge clk); #1; sclk_in = 1'b1;
            if (skew == 0) sdata_in = sq[i];
            for (int c = 1; c < hi; c++) begin
                @(posedge clk); #1;
                if (c == skew) sdata_in = sq[i];
            end
            @(posedge clk); #1; sclk_in = 1'b0;
            for (int c = 1; c < lo; c++) begin @(posedge clk); #1; end
        end
        sent = sq.size();
        repeat (12) @(posedge clk);
        #1;
    endtask

    // Parse the whole bit list from the idle state into the expected strobe sequence.
    task automatic model_run();
        int p, n;
        p = 0; n = sq.size();
        exp_q.delete();
        while (p < n) begin
            int z, led, k;
            bit bad;
            logic [31:0] w;
            z = 0;
            while (p < n && z < 32) begin z = sq[p] ? 0 : z + 1; p++; end
            if (z < 32) break;
            while (p < n && sq[p] == 1'b0) p++;
            if (p >= n) break;
            exp_q.push_back(mk(K_S, '0, '0));
            led = 0; bad = 1'b0;
            while (led < NUM_LEDS) begin
                if (p + 32 > n) return;
                w = '0;
                for (int j = 0; j < 32; j++) w = {w[30:0], logic'(sq[p + j])};
                p += 32;
                if (w[31:29] != 3'b111) begin
                    exp_q.push_back(mk(K_E, '0, '0));
                    bad = 1'b1;
                    break;
                end
                exp_q.push_back(mk(K_P, IDX_W'(led), w[28:0]));
                led++;
            end
            if (bad) continue;
            k = 0;
            while (p < n && k < 32 && sq[p] == 1'b0) begin k++; p++; end
            if (k == 32) exp_q.push_back(mk(K_D, '0, '0));
            else if (p < n) begin exp_q.push_back(mk(K_E, '0, '0)); p++; end
            else break;
        end
    endtask

    task automatic check_events(input string tag);
        int n_obs, n;
        model_run();
        n_obs = obs_q.size() - obs_rd;
        chk({tag, " count"}, 64'(n_obs), 64'(exp_q.size()));
        n = (n_obs < exp_q.size()) ? n_obs : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s ev%0d", tag, i), 64'(obs_q[obs_rd + i]), 64'(exp_q[i]));
        chk({tag, " exclusive"}, 64'(multi - multi_base), 64'd0);
        obs_rd = obs_q.size();
        multi_base = multi;
    endtask

    task automatic do_reset();
        reset = 1'b1; sclk_in = 1'b0; sdata_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sq.delete(); sent = 0;
        obs_rd = obs_q.size(); multi_base = multi;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " strobes"}, 64'({pix_valid, frame_start, frame_done, frame_err}), 64'd0);
        chk({tag, " index"}, 64'(pix_index), 64'd0);
        chk({tag, " fields"}, 64'({pix_bright, pix_blue, pix_green, pix_red}), 64'd0);
        chk({tag, " busy"}, 64'(rx_busy), 64'd0);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk_all_zero("reset");

        // Full frame of constant words, extra zeros after the end frame
        push_zeros(32);
        for (int i = 0; i < NUM_LEDS; i++) push_word(32'hF0000F00);
        push_zeros(64);
        send(3, 3);
        check_events("full");
        chk("full busy", 64'(rx_busy), 64'd0);
        chk("full last idx", 64'(pix_index), 64'd63);
        chk("full fields", 64'({pix_bright, pix_blue, pix_green, pix_red}), 64'({5'h10, 8'h00, 8'h0F, 8'h00}));

        // False sync: a 1 after 31 zeros restarts the hunt
        do_reset();
        push_zeros(31); sq.push_back(1'b1); push_zeros(32); push_word(32'hE1FF8001);
        send(4, 5);
        check_events("falsesync");
        chk("falsesync fields", 64'({pix_bright, pix_blue, pix_green, pix_red}), 64'({5'h01, 8'hFF, 8'h80, 8'h01}));
        chk("falsesync idx", 64'(pix_index), 64'd0);
        chk("falsesync busy", 64'(rx_busy), 64'd1);

        // Bad header on word 1, then re-sync
        do_reset();
        push_zeros(32); push_word(32'hF0070000); push_word(32'h70000000);
        send(3, 3);
        chk("badhdr busy", 64'(rx_busy), 64'd0);
        push_zeros(32); push_word(rnd_word());
        send(3, 3);
        check_events("badhdr");

        // End-frame violation after a full random frame
        do_reset();
        push_zeros(32);
        for (int i = 0; i < NUM_LEDS; i++) push_word(rnd_word());
        push_zeros(10); sq.push_back(1'b1);
        send(3, 3);
        check_events("endviol");
        chk("endviol busy", 64'(rx_busy), 64'd0);

        // Reset after bit 17 of pixel 5
        do_reset();
        push_zeros(32);
        for (int i = 0; i < 5; i++) push_word(rnd_word());
        sq.push_back(1'b1);
        for (int i = 1; i < 17; i++) sq.push_back(1'($urandom));
        send(3, 3);
        check_events("premid");
        chk("premid busy", 64'(rx_busy), 64'd1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("midreset");
        do_reset();
        push_zeros(32);
        for (int i = 0; i < 3; i++) push_word(rnd_word());
        send(3, 3);
        check_events("postreset");

        // Same stream at fastest and slow sclk rates
        for (int i = 0; i < 6; i++) words[i] = rnd_word();
        do_reset();
        push_zeros(32);
        for (int i = 0; i < 6; i++) push_word(words[i]);
        send(3, 3);
        check_events("fast");
        do_reset();
        push_zeros(32);
        for (int i = 0; i < 6; i++) push_word(words[i]);
        send(50, 50);
        check_events("slow");
        chk("slow busy", 64'(rx_busy), 64'd1);
        chk("slow last", 64'({pix_bright, pix_blue, pix_green, pix_red}), 64'(words[5][28:0]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/apa102_stream_rx.md
Name: apa102_stream_rx

Overview:
- Receiver for the two-wire LED-matrix stream (serial clock plus serial data) that our matrix display blocks drive.
- Frame format: 32-bit all-zero start frame, then NUM_LEDS 32-bit pixel words sent MSB first, then an all-zero end frame.
- Recovers each pixel word and presents it in parallel with an index and a valid strobe.
- Used as a bench/loopback monitor and as a front end for chaining a downstream matrix; runs on its own oversampling clock.

Parameters:
- NUM_LEDS, 64, pixel words per frame.
- IDX_W, 6, width of pix_index; must satisfy 2^IDX_W >= NUM_LEDS.

Ports:
- clk  input  1  system clock; oversamples the serial lines.
- reset  input  1  synchronous, active-high.
- sclk_in  input  1  serial clock, asynchronous to clk.
- sdata_in  input  1  serial data, asynchronous to clk.
- pix_valid  output  1  one-clk strobe; a pixel word has been accepted.
- pix_index  output  IDX_W  position of the pixel in the frame, 0..NUM_LEDS-1.
- pix_bright  output  5  global brightness field, word bits 28:24.
- pix_blue  output  8  word bits 23:16.
- pix_green  output  8  word bits 15:8.
- pix_red  output  8  word bits 7:0.
- frame_start  output  1  one-clk strobe on the first bit of pixel 0.
- frame_done  output  1  one-clk strobe when the end frame is complete.
- frame_err  output  1  one-clk strobe on a protocol violation.
- rx_busy  output  1  high in states PIXEL and END.

Behaviour:
- Input sampling:
  - sclk_in and sdata_in each pass through a 2-flop synchronizer; sclk edge detect uses a third flop.
  - A bit is sampled on the detected falling edge of sclk, using the synchronized sdata value. The transmitter launches data with the rising edge.
  - Requirement: sclk high and low phases are each >= 3 clk cycles. Behaviour is undefined below that.
  - Rising edges are otherwise ignored.
- State machine (one transition per sampled bit):
  - HUNT: zero_run counter, 6 bits, saturating at 32. A 0 bit increments it; a 1 bit clears it. When zero_run reaches 32, go to SYNC.
  - SYNC: extra 0 bits are ignored. A 1 bit pulses frame_start, loads the shift register with 1, sets bit_cnt=1 and led_cnt=0, and goes to PIXEL.
  - PIXEL: each bit shifts into a 32-bit register (MSB first) and bit_cnt increments. On the 32nd bit, check the header in bits 31:29:
    - 111: latch the fields, drive pix_index=led_cnt, pulse pix_valid, then led_cnt++. If led_cnt was NUM_LEDS-1, go to END with zero_run=0; otherwise reset bit_cnt=0 and stay in PIXEL.
    - Anything else: pulse frame_err, emit no pix_valid, go to HUNT with zero_run=0.
  - END: a 0 bit increments zero_run. On reaching 32, pulse frame_done and go to HUNT with zero_run=0. A 1 bit pulses frame_err and goes to HUNT with zero_run=0.
- Timing:
  - All strobes assert in the clk cycle after the cycle in which the falling edge is detected, and last exactly one cycle.
  - The pixel fields and pix_index hold their values until the next pix_valid.
- Reset:
  - All outputs go to 0, state to HUNT, and all counters and the shift register clear.
  - Reset mid-frame discards the partial word and raises no strobes.
  - Synchronizer flops also reset to 0, so a high sclk at reset release does not produce a false edge.
- Strobe exclusivity: at most one of pix_valid, frame_start, frame_done, frame_err asserts per cycle.
- Framing rules:
  - Back-to-back frames are legal: the 32-zero end frame, followed by at least 32 further zeros, re-syncs.
  - A frame with fewer than NUM_LEDS words followed by zeros simply stalls in PIXEL until it receives 1 bits. There is no timeout.

Test Plan:
- Full frame: 32 zeros, 64 words of 0xF0000F00, 64 zeros -> frame_start once, then 64 pix_valid with index 0..63, bright=0x10, blue=0x00, green=0x0F, red=0x00, then one frame_done, no frame_err.
- False sync: 31 zeros, a 1, then 32 zeros and one word 0xE1FF8001 -> no activity before the second zero run; frame_start, then pix_valid index 0 with bright=0x01, blue=0xFF, green=0x80, red=0x01.
- Bad header: valid sync, word 0 = 0xF0070000, word 1 = 0x70000000 -> pix_valid for index 0; frame_err on word 1's 32nd bit; rx_busy=0; a following 32 zeros plus valid word re-syncs with index 0.
- End-frame violation: full 64-word frame, then 10 zeros and a 1 -> frame_err, no frame_done, state HUNT.
- Reset mid-word: assert reset after bit 17 of pixel 5 -> all outputs 0 the next cycle; a fresh frame afterwards yields indices starting at 0.
- Slow/fast sclk: half periods of 3 clk and of 50 clk with random sdata transition skew within the high phase -> identical decoded pixel sequence in both runs.
